// File: rtl/ctrl_pkg.sv
// Shared types and defaults for the vector ASIP issue-stage control logic.
package ctrl_pkg;

  localparam int WB_LAT_DEF  = 3;
  localparam int RADDR_W_DEF = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [1:0] {
    RSEL_BOTH = 2'b00,
    RSEL_R2   = 2'b01,
    RSEL_R3   = 2'b10,
    RSEL_NONE = 2'b11
  } rsel_t;

  typedef logic [RADDR_W_DEF-1:0] raddr_t;

  function automatic logic uses_r2(rsel_t s);
    return (s == RSEL_BOTH) || (s == RSEL_R2);
  endfunction

  function automatic logic uses_r3(rsel_t s);
    return (s == RSEL_BOTH) || (s == RSEL_R3);
  endfunction

endpackage

// File: rtl/hazard_timer.sv
// Per-register write-back countdown: loads LAT on issue of a write, then counts to zero.
module hazard_timer
  import ctrl_pkg::*;
#(
  parameter int LAT = WB_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic live_o,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  // live_o is the pre-edge state used for the hazard lookup; busy_o is the registered view
  assign live_o = (cnt_q != '0);
  assign busy_o = busy_q;

endmodule

// File: rtl/operand_hazard_scoreboard.sv
// Issue-stage RAW hazard detector: stalls decode while a read operand has an in-flight write.
module operand_hazard_scoreboard
  import ctrl_pkg::*;
#(
  parameter int NREG    = 16,
  parameter int RADDR_W = 4,
  parameter int WB_LAT  = WB_LAT_DEF,
  parameter int SCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         rsel,
  input  logic [RADDR_W-1:0] ra2,
  input  logic [RADDR_W-1:0] ra3,
  input  logic [RADDR_W-1:0] rd,
  input  logic               wr_en,
  input  logic               dec_valid,
  input  logic               flush,
  output logic               dec_ready,
  output logic               issue,
  output logic [NREG-1:0]    busy_vec,
  output logic [SCNT_W-1:0]  stall_cnt
);

  rsel_t            rsel_e;
  logic [NREG-1:0]  live;
  logic             hazard;
  logic [SCNT_W-1:0] stall_q, stall_d;

  assign rsel_e = rsel_t'(rsel);

  for (genvar i = 0; i < NREG; i++) begin : g_timer
    hazard_timer #(.LAT(WB_LAT)) u_timer (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (issue & wr_en & (rd == RADDR_W'(i))),
      .live_o (live[i]),
      .busy_o (busy_vec[i])
    );
  end

  // Same-instruction rd never matters here: lookups see only pre-edge counters
  assign hazard    = (uses_r2(rsel_e) & live[ra2]) | (uses_r3(rsel_e) & live[ra3]);
  assign dec_ready = ~hazard & ~flush;
  assign issue     = dec_valid & dec_ready;

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && hazard && !flush && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else
      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random traffic against a time-stamp reference model.
module tb_operand_hazard_scoreboard;

  localparam int NREG   = 16;
  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rsel = 2'b11;
  logic [3:0]  ra2 = '0, ra3 = '0, rd = '0;
  logic        wr_en = 1'b0, dec_valid = 1'b0, flush = 1'b0;
  logic        dec_ready, issue;
  logic [15:0] busy_vec;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Model: register r is readable from cycle ready_at[r] onward
  int ready_at [NREG];
  int cyc = 0;
  int stall_m = 0;

  operand_hazard_scoreboard #(.NREG(NREG), .RADDR_W(4), .WB_LAT(WB_LAT), .SCNT_W(16)) dut (
    .clk(clk), .rst(rst), .rsel(rsel), .ra2(ra2), .ra3(ra3), .rd(rd), .wr_en(wr_en),
    .dec_valid(dec_valid), .flush(flush), .dec_ready(dec_ready), .issue(issue),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic model_hazard(input logic [1:0] s, input int a2, input int a3);
    logic u2, u3;
    u2 = (s == 2'b00) || (s == 2'b01);
    u3 = (s == 2'b00) || (s == 2'b10);
    return (u2 && cyc < ready_at[a2]) || (u3 && cyc < ready_at[a3]);
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < NREG; r++) b[r] = (cyc < ready_at[r]);
    return b;
  endfunction

  // Entered and left at a falling edge
  task automatic step(input logic [1:0] s, input int a2, input int a3, input int d,
                      input logic we, input logic v, input logic fl);
    logic haz, rdy, iss;
    rsel = s; ra2 = 4'(a2); ra3 = 4'(a3); rd = 4'(d);
    wr_en = we; dec_valid = v; flush = fl;
    #1;
    haz = model_hazard(s, a2, a3);
    rdy = !haz && !fl;
    iss = v && rdy;
    chk("dec_ready", 32'(dec_ready), 32'(rdy));
    chk("issue", 32'(issue), 32'(iss));
    chk("busy_vec", 32'(busy_vec), 32'(model_busy()));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    @(posedge clk);
    if (iss && we) ready_at[d] = cyc + WB_LAT + 1;
    if (v && haz && !fl && stall_m < 65535) stall_m++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; dec_valid = 1'b0; flush = 1'b0; wr_en = 1'b0;
    #1;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    stall_m = 0;
    chk("rst_busy_vec", 32'(busy_vec), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_dec_ready", 32'(dec_ready), 32'h1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    @(negedge clk);
    do_reset();

    // Reset then plain read of R1/R2
    step(2'b00, 1, 2, 0, 1'b0, 1'b1, 1'b0);

    // Write R5 then an R2-reader of R5: three stall cycles, then issue
    step(2'b11, 0, 0, 5, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(2'b01, 5, 0, 0, 1'b0, 1'b1, 1'b0);
    #1 chk("stall_after_r5", 32'(stall_cnt), 32'd3);
    #1;

    // Pending R5, instruction reading no operands
    step(2'b11, 0, 0, 5, 1'b1, 1'b1, 1'b0);
    step(2'b11, 5, 5, 0, 1'b0, 1'b1, 1'b0);

    // Pending R7 with flush: blocked, no stall counting, counter drains
    step(2'b11, 0, 0, 7, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < WB_LAT + 1; k++) step(2'b10, 0, 7, 0, 1'b0, 1'b1, 1'b1);
    #1 chk("r7_drained", 32'(busy_vec[7]), 32'd0);
    #1;

    // WAW reload on R3, then reader of R3
    step(2'b11, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    step(2'b11, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 0, 0, 3, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(2'b10, 0, 3, 0, 1'b0, 1'b1, 1'b0);

    // Self-dependency and duplicate source on a busy register
    step(2'b11, 0, 0, 4, 1'b1, 1'b1, 1'b0);
    step(2'b00, 4, 4, 4, 1'b1, 1'b1, 1'b0);
    step(2'b00, 6, 6, 6, 1'b1, 1'b1, 1'b0);

    // Reset mid-countdown on R9, reader issues right after release
    step(2'b11, 0, 0, 9, 1'b1, 1'b1, 1'b0);
    step(2'b11, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(2'b01, 9, 0, 0, 1'b0, 1'b1, 1'b0);

    // Random traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(2'($urandom_range(0, 3)), $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
